// File: rtl/multicycle_core_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_core_fsm
//   Control sequencer for the multi-cycle RV32I datapath. Each instruction
//   goes through FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK). The
//   sequencer issues the memory handshake and drives the datapath mux selects
//   and write strobes. Supported: LUI, AUIPC, OP-IMM, OP, LW, SW, BEQ/BNE.
//   Any other instruction sends it to TRAP, where it stays until reset.
//
// Parameters
//   MEM_TIMEOUT   cycles to wait for mem_ready before a bus error (1..255)
//
// Ports
//   clk, rst_n        core clock (rising edge), synchronous active-low reset
//   instr_opcode/f3   IR fields, sampled in DECODE
//   alu_zero          ALU result is zero (branch resolution)
//   mem_ready         memory completes the pending request this cycle
//   mem_req/we/addr_sel, ir_write, pc_write, pc_src   memory and PC control
//   alu_option, alu_src_a, alu_src_b                  ALU control
//   reg_write, wb_sel                                 register write-back
//   instr_retired     one-cycle pulse per completed instruction
//   illegal_instr     sticky decode trap flag
//   bus_error         sticky memory timeout flag
//   state_dbg         current state code (TRAP = 7)
// ---------------------------------------------------------------------------
module multicycle_core_fsm #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] instr_opcode,
    input  logic [2:0] instr_funct3,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [3:0] alu_option,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       wb_sel,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd7
    } state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Value of the wait counter on the waiting cycle that exhausts the budget.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q,     state_d;
    logic [7:0] tmo_cnt_q,   tmo_cnt_d;
    logic [6:0] opcode_q,    opcode_d;
    logic [2:0] funct3_q,    funct3_d;
    logic       illegal_q,   illegal_d;
    logic       bus_err_q,   bus_err_d;
    logic       br_taken_s;

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        logic ok;
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: ok = 1'b1;
            OPC_LOAD, OPC_STORE:                   ok = (f3 == 3'b010);
            OPC_BRANCH:                            ok = (f3 == 3'b000) || (f3 == 3'b001);
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // BEQ takes on zero, BNE on non-zero.
    assign br_taken_s = (funct3_q == 3'b000) ? alu_zero : ~alu_zero;

    // Next-state, wait-counter, latched-IR and sticky-flag computation.
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = 8'd0;       // only a waiting handshake keeps counting
        opcode_d  = opcode_q;
        funct3_d  = funct3_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    if (state_q == S_FETCH) begin
                        state_d = S_DECODE;
                    end else if (opcode_q == OPC_STORE) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                opcode_d = instr_opcode;
                funct3_d = instr_funct3;
                if (is_legal(instr_opcode, instr_funct3)) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXECUTE: begin
                case (opcode_q)
                    OPC_LOAD, OPC_STORE: state_d = S_MEM;
                    OPC_BRANCH:          state_d = S_FETCH;
                    default:             state_d = S_WRITEBACK;
                endcase
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;   // unused encodings are treated as a fault
        endcase
    end

    // Single state register bank with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            tmo_cnt_q <= 8'd0;
            opcode_q  <= 7'd0;
            funct3_q  <= 3'd0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Output decode from the state and latched IR; reset forces everything low.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        alu_option    = 4'b0000;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        reg_write     = 1'b0;
        wb_sel        = 1'b0;
        instr_retired = 1'b0;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;
        state_dbg     = 3'd0;
        if (rst_n) begin
            state_dbg     = state_q;
            illegal_instr = illegal_q;
            bus_error     = bus_err_q;
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end else begin
                        ir_write = 1'b0;
                        pc_write = 1'b0;
                    end
                end
                S_EXECUTE: begin
                    alu_option = opcode_q[6:3];
                    case (opcode_q)
                        OPC_OPIMM, OPC_LOAD, OPC_STORE: alu_src_b = 2'b01;
                        OPC_LUI: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 2'b01;
                        end
                        OPC_AUIPC: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b01;
                        end
                        default: begin
                            alu_src_a = 2'b00;
                            alu_src_b = 2'b00;
                        end
                    endcase
                    if (opcode_q == OPC_BRANCH) begin
                        pc_write      = br_taken_s;
                        pc_src        = br_taken_s;
                        instr_retired = 1'b1;
                    end else begin
                        instr_retired = 1'b0;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (opcode_q == OPC_STORE);
                    if (mem_ready) begin
                        instr_retired = (opcode_q == OPC_STORE);
                    end else begin
                        instr_retired = 1'b0;
                    end
                end
                S_WRITEBACK: begin
                    reg_write     = 1'b1;
                    wb_sel        = (opcode_q == OPC_LOAD);
                    instr_retired = 1'b1;
                end
                default: begin
                    // DECODE and TRAP drive no strobes.
                    mem_req = 1'b0;
                end
            endcase
        end else begin
            state_dbg = 3'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_core_fsm.sv
module tb_multicycle_core_fsm;

    localparam int TMO = 4;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] instr_opcode = 7'd0;
    logic [2:0] instr_funct3 = 3'd0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic [3:0] alu_option;
    logic [1:0] alu_src_a, alu_src_b;
    logic       reg_write, wb_sel, instr_retired, illegal_instr, bus_error;
    logic [2:0] state_dbg;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [3:0] alu_option;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       wb_sel;
        logic       instr_retired;
        logic       illegal_instr;
        logic       bus_error;
        logic [2:0] state_dbg;
    } outs_t;

    outs_t obs;
    assign obs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                  alu_option, alu_src_a, alu_src_b, reg_write, wb_sel,
                  instr_retired, illegal_instr, bus_error, state_dbg};

    multicycle_core_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_opcode(instr_opcode), .instr_funct3(instr_funct3),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_option(alu_option), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .wb_sel(wb_sel), .instr_retired(instr_retired),
        .illegal_instr(illegal_instr), .bus_error(bus_error), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic       m_ill    = 1'b0;   // model sticky flags
    logic       m_bus    = 1'b0;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            LUI, AUIPC, OPIMM, OPR: return 1'b1;
            LOAD, STORE:            return f3 == 3'b010;
            BRANCH:                 return f3 == 3'b000 || f3 == 3'b001;
            default:                return 1'b0;
        endcase
    endfunction

    // ALU source selects {src_a, src_b} per instruction class.
    function automatic logic [3:0] srcs(input logic [6:0] op);
        case (op)
            OPIMM, LOAD, STORE: return 4'b0001;
            LUI:                return 4'b1001;
            AUIPC:              return 4'b0101;
            default:            return 4'b0000;
        endcase
    endfunction

    function automatic outs_t idle(input logic [2:0] st);
        outs_t e;
        e = '0;
        e.state_dbg     = st;
        e.illegal_instr = m_ill;
        e.bus_error     = m_bus;
        return e;
    endfunction

    task automatic step(input logic rdy, input logic zero, input logic drive_ir,
                        input outs_t e, input string tag);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = rdy;
        alu_zero  = zero;
        if (drive_ir) begin
            instr_opcode = cur_op;
            instr_funct3 = cur_f3;
        end else begin
            instr_opcode = 7'($urandom);
            instr_funct3 = 3'($urandom);
        end
        #1;
        check_eq(tag, 32'(obs), 32'(e));
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst_n        = 1'b0;
        mem_ready    = 1'($urandom);
        alu_zero     = 1'($urandom);
        instr_opcode = 7'($urandom);
        instr_funct3 = 3'($urandom);
        #1;
        check_eq("reset", 32'(obs), 32'd0);
        m_ill = 1'b0;
        m_bus = 1'b0;
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++)
            step(1'($urandom), 1'($urandom), 1'b0, idle(3'd7), "trap");
        reset_cycle();
    endtask

    // res: 0 = completed, 1 = timed out, 2 = aborted by reset
    task automatic handshake(input int waits, input outs_t e_wait, input outs_t e_done,
                             input int abort_at, input string tag, output int res);
        res = 0;
        for (int k = 0; k <= waits; k++) begin
            if (k == abort_at) begin
                reset_cycle();
                res = 2;
                return;
            end
            if (k == waits) begin
                step(1'b1, 1'($urandom), 1'b0, e_done, tag);
                return;
            end
            step(1'b0, 1'($urandom), 1'b0, e_wait, tag);
            if (k + 1 == TMO) begin
                m_bus = 1'b1;
                res = 1;
                return;
            end
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int fw,
                             input int mw, input logic zero, input int abort_f,
                             input int abort_m, input int trap_n);
        outs_t e, ed;
        int    res;
        logic  taken;
        cur_op = op;
        cur_f3 = f3;
        e = idle(3'd0);
        e.mem_req = 1'b1; e.alu_src_a = 2'b01; e.alu_src_b = 2'b10;
        ed = e; ed.ir_write = 1'b1; ed.pc_write = 1'b1;
        handshake(fw, e, ed, abort_f, "fetch", res);
        if (res == 1) begin trap_hold(trap_n); return; end
        if (res == 2) return;
        step(1'($urandom), 1'($urandom), 1'b1, idle(3'd1), "decode");
        if (!legal(op, f3)) begin
            m_ill = 1'b1;
            trap_hold(trap_n);
            return;
        end
        e = idle(3'd2);
        e.alu_option = op[6:3];
        {e.alu_src_a, e.alu_src_b} = srcs(op);
        if (op == BRANCH) begin
            taken = (f3 == 3'b000) ? zero : !zero;
            e.pc_write = taken; e.pc_src = taken; e.instr_retired = 1'b1;
        end
        step(1'($urandom), zero, 1'b0, e, "execute");
        if (op == BRANCH) return;
        if (op == LOAD || op == STORE) begin
            e = idle(3'd3);
            e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = (op == STORE);
            ed = e; ed.instr_retired = (op == STORE);
            handshake(mw, e, ed, abort_m, "mem", res);
            if (res == 1) begin trap_hold(trap_n); return; end
            if (res == 2 || op == STORE) return;
        end
        e = idle(3'd4);
        e.reg_write = 1'b1; e.wb_sel = (op == LOAD); e.instr_retired = 1'b1;
        step(1'($urandom), 1'($urandom), 1'b0, e, "writeback");
    endtask

    logic [6:0] op_tab [8];
    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        int         fw, mw, af, am;
        op_tab = '{LUI, AUIPC, OPIMM, OPR, LOAD, STORE, BRANCH, JAL};
        reset_cycle();
        reset_cycle();
        // Directed scenarios
        run_instr(OPIMM, 3'b000, 0, 0, 1'b0, -1, -1, 3);            // ADDI
        run_instr(LOAD, 3'b010, 3, 3, 1'b0, -1, -1, 3);             // LW, 3 waits each
        run_instr(BRANCH, 3'b000, 0, 0, 1'b1, -1, -1, 3);           // BEQ taken
        run_instr(BRANCH, 3'b001, 0, 0, 1'b1, -1, -1, 3);           // BNE not taken
        run_instr(BRANCH, 3'b000, 1, 0, 1'b0, -1, -1, 3);           // BEQ not taken
        run_instr(BRANCH, 3'b001, 0, 0, 1'b0, -1, -1, 3);           // BNE taken
        run_instr(JAL, 3'b000, 0, 0, 1'b0, -1, -1, 20);             // illegal -> trap
        run_instr(LUI, 3'b101, 0, 0, 1'b0, -1, -1, 3);
        run_instr(AUIPC, 3'b000, 2, 0, 1'b0, -1, -1, 3);
        run_instr(OPR, 3'b111, 0, 0, 1'b0, -1, -1, 3);
        run_instr(STORE, 3'b010, 0, 10, 1'b0, -1, -1, 3);           // MEM timeout
        run_instr(LOAD, 3'b010, 0, TMO - 1, 1'b0, -1, -1, 3);       // ready on last allowed cycle
        run_instr(OPIMM, 3'b000, TMO, 0, 1'b0, -1, -1, 3);          // FETCH timeout
        run_instr(STORE, 3'b010, 0, 3, 1'b0, -1, 1, 3);             // reset mid-MEM
        run_instr(STORE, 3'b010, 0, 0, 1'b0, -1, -1, 3);
        run_instr(LOAD, 3'b011, 0, 0, 1'b0, -1, -1, 2);             // bad LW funct3
        run_instr(BRANCH, 3'b100, 0, 0, 1'b0, -1, -1, 2);           // BLT unsupported
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            else op = op_tab[$urandom_range(0, 7)];
            f3 = 3'($urandom);
            if ((op == LOAD || op == STORE) && $urandom_range(0, 3) != 0) f3 = 3'b010;
            if (op == BRANCH && $urandom_range(0, 3) != 0) f3 = {2'b00, 1'($urandom)};
            fw = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TMO + 1) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TMO + 1) : $urandom_range(0, 2);
            af = ($urandom_range(0, 19) == 0) ? $urandom_range(0, fw) : -1;
            am = ($urandom_range(0, 19) == 0) ? $urandom_range(0, mw) : -1;
            run_instr(op, f3, fw, mw, 1'($urandom), af, am, $urandom_range(1, 4));
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
